fetch_redirect_ctrl: RTL
========================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter PCLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter BOOT_CYCLES, default 4, cycles held in BOOT after reset release (range 1..255).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports EX_taken input 1 and EX_alt_pc input PCLEN: branch/jump redirect request and its target.
REQ-006 SHALL have ports trap_req input 1 and trap_vec input PCLEN: trap redirect request and its vector.
REQ-007 SHALL have ports halt_req input 1, resume_req input 1 and resume_pc input PCLEN: debug halt, debug resume and resume target.
REQ-008 SHALL have ports stall_D input 1 (decode stall) and imem_ready input 1 (instruction memory accepts a fetch this cycle).
REQ-009 SHALL have ports pc_taken output 1, pc_alt_pc output PCLEN and pc_stall output 1, driving the PC register's taken, alternate-PC and stall inputs.
REQ-010 SHALL have ports flush_FD output 1 (kill F/D stages), halted output 1, state output 2 and redirect_cnt output 16.

Function
REQ-011 SHALL implement states BOOT=0, RUN=1, PEND=2, HALT=3; outputs are combinational from state, registers and current inputs.
REQ-012 BOOT: pc_stall=1; redirect, halt and resume inputs ignored; a counter moves the state to RUN after exactly BOOT_CYCLES cycles.
REQ-013 RUN redirect priority: trap_req > EX_taken; selected target is trap_vec or EX_alt_pc respectively.
REQ-014 RUN, redirect present, imem_ready=1: pc_taken=1, pc_alt_pc=selected target, flush_FD=1 in the same cycle, pc_stall=0; state stays RUN.
REQ-015 RUN, redirect present, imem_ready=0: pc_taken=0, pc_stall=1; latch the selected target into pend_pc; next state PEND.
REQ-016 RUN, no redirect: pc_taken=0, flush_FD=0, pc_stall = stall_D OR NOT imem_ready.
REQ-017 RUN, halt_req=1 and no redirect: next state HALT; a simultaneous redirect wins and halt_req is ignored that cycle.
REQ-018 PEND: pc_stall=1 until imem_ready=1; then pc_taken=1, pc_alt_pc=pend_pc, flush_FD=1; next state RUN.
REQ-019 PEND: trap_req=1 overwrites pend_pc with trap_vec; if imem_ready=1 in the same cycle, trap_vec is issued directly; EX_taken and halt_req are ignored.
REQ-020 HALT: halted=1, pc_stall=1; trap_req and EX_taken are ignored.
REQ-021 HALT, resume_req=1 and imem_ready=1: pc_taken=1, pc_alt_pc=resume_pc, flush_FD=1; next state RUN. If imem_ready=0, the block stays in HALT.
REQ-022 redirect_cnt SHALL increment by 1 on every cycle with pc_taken=1 and wrap from 0xFFFF to 0.
REQ-023 pc_alt_pc SHALL be 0 whenever pc_taken=0.

Reset
REQ-024 rst=1 SHALL immediately force: state BOOT, boot counter 0, pend_pc 0, redirect_cnt 0.
REQ-025 While rst=1, outputs SHALL be: pc_taken=0, pc_alt_pc=0, pc_stall=1, flush_FD=0, halted=0.
REQ-026 Reset asserted mid-PEND or mid-HALT SHALL discard the pending target; no redirect is issued after reset release.

Structure
REQ-027 Package fetch_ctrl_pkg SHALL hold the state encoding constants and the redirect-source priority constants.
REQ-028 Sub-module fetch_redirect_arb SHALL contain the combinational trap/EX priority select, producing a valid bit and a target; all sequential logic stays in fetch_redirect_ctrl.

Verification
REQ-029 Reset release with BOOT_CYCLES=4 -> pc_stall=1 for 4 cycles, then state=RUN and pc_stall=0 (stall_D=0, imem_ready=1).
REQ-030 RUN: EX_taken=1, EX_alt_pc=0x100, trap_req=1, trap_vec=0x80 in the same cycle -> pc_taken=1, pc_alt_pc=0x80, flush_FD=1, redirect_cnt+1.
REQ-031 RUN: EX_taken=1 to 0x200 with imem_ready=0 for 3 cycles -> PEND with pc_stall=1 for 3 cycles; on the ready cycle pc_taken=1 to 0x200, then RUN.
REQ-032 PEND holding 0x200, trap_req=1 to 0x80 while imem_ready=0 -> the redirect later issued is 0x80, not 0x200.
REQ-033 halt_req in RUN -> HALT with halted=1; EX_taken is ignored; resume_req with resume_pc=0x400 and imem_ready=1 -> pc_taken=1 to 0x400, then RUN.
REQ-034 redirect_cnt preloaded to 0xFFFF by forcing 65535 redirects, then one more redirect -> redirect_cnt=0x0000; rst during PEND -> BOOT, no redirect issued.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: FSM states and
// redirect-source priority (a higher source value wins arbitration).
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EX   = 2'd1,
    SRC_TRAP = 2'd2
  } src_t;

  function automatic src_t sel_src(input logic trap, input logic ex);
    if (trap) return SRC_TRAP;
    if (ex)   return SRC_EX;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// Combinational trap-over-branch redirect select: valid bit plus chosen target.
module fetch_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter int PCLEN = 32
) (
  input  logic             trap_req,
  input  logic [PCLEN-1:0] trap_vec,
  input  logic             EX_taken,
  input  logic [PCLEN-1:0] EX_alt_pc,
  output logic             vld,
  output logic [PCLEN-1:0] target
);

  src_t src;

  always_comb begin
    src = sel_src(trap_req, EX_taken);
    vld = (src != SRC_NONE);
    case (src)
      SRC_TRAP: target = trap_vec;
      SRC_EX:   target = EX_alt_pc;
      default:  target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: boot hold, branch/trap redirect with a pending
// slot for when imem is busy, and debug halt/resume.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PCLEN       = 32,
  parameter int BOOT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_taken,
  input  logic [PCLEN-1:0] EX_alt_pc,
  input  logic             trap_req,
  input  logic [PCLEN-1:0] trap_vec,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic [PCLEN-1:0] resume_pc,
  input  logic             stall_D,
  input  logic             imem_ready,
  output logic             pc_taken,
  output logic [PCLEN-1:0] pc_alt_pc,
  output logic             pc_stall,
  output logic             flush_FD,
  output logic             halted,
  output logic [1:0]       state,
  output logic [15:0]      redirect_cnt
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_t           st_q, st_d;
  logic [7:0]       boot_cnt;
  logic [PCLEN-1:0] pend_pc;
  logic [15:0]      cnt_q;
  logic             rd_vld;
  logic [PCLEN-1:0] rd_pc;

  fetch_redirect_arb #(.PCLEN(PCLEN)) u_arb (
    .trap_req  (trap_req),
    .trap_vec  (trap_vec),
    .EX_taken  (EX_taken),
    .EX_alt_pc (EX_alt_pc),
    .vld       (rd_vld),
    .target    (rd_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_BOOT;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_BOOT: if (boot_cnt == BOOT_LAST) st_d = ST_RUN;
      ST_RUN: begin
        if (rd_vld && !imem_ready)  st_d = ST_PEND;
        else if (!rd_vld && halt_req) st_d = ST_HALT;
      end
      ST_PEND: if (imem_ready) st_d = ST_RUN;
      ST_HALT: if (resume_req && imem_ready) st_d = ST_RUN;
      default: st_d = ST_BOOT;
    endcase
  end

  // A redirect always flushes F/D in the cycle it is handed to the PC.
  always_comb begin
    pc_taken  = 1'b0;
    pc_alt_pc = '0;
    pc_stall  = 1'b1;
    flush_FD  = 1'b0;
    halted    = 1'b0;
    case (st_q)
      ST_RUN: begin
        if (rd_vld) begin
          if (imem_ready) begin
            pc_taken  = 1'b1;
            pc_alt_pc = rd_pc;
            flush_FD  = 1'b1;
            pc_stall  = 1'b0;
          end
        end else begin
          pc_stall = stall_D || !imem_ready;
        end
      end
      ST_PEND: begin
        if (imem_ready) begin
          pc_taken  = 1'b1;
          pc_alt_pc = trap_req ? trap_vec : pend_pc;
          flush_FD  = 1'b1;
          pc_stall  = 1'b0;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume_req && imem_ready) begin
          pc_taken  = 1'b1;
          pc_alt_pc = resume_pc;
          flush_FD  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A trap arriving while a branch target waits replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_cnt <= '0;
      pend_pc  <= '0;
      cnt_q    <= '0;
    end else begin
      if (st_q == ST_BOOT) boot_cnt <= boot_cnt + 8'd1;
      if (st_q == ST_RUN && rd_vld && !imem_ready) pend_pc <= rd_pc;
      else if (st_q == ST_PEND && trap_req)        pend_pc <= trap_vec;
      if (pc_taken) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign state        = st_q;
  assign redirect_cnt = cnt_q;

endmodule
